// File: rtl/rr_mux4x1_311.sv
// Four-channel round-robin merge onto one registered output slot, tagged with source index.
// Latency: one clock from input acceptance to vy_311; 1 word/clock sustained while ry=1.
// Backpressure: ry=0 with a held word stalls the slot; every rdy_311 bit drops until it drains.
module rr_mux4x1_311 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic [3:0]       v,
    output logic [3:0]       rdy_311,
    output logic [WIDTH-1:0] y_311,
    output logic             vy_311,
    input  logic             ry,
    output logic             s1_311,
    output logic             s0_311,
    output logic [CNT_W-1:0] cnt_311
);

    logic [1:0]       r_lp;
    logic [WIDTH-1:0] r_y;
    logic             r_vy;
    logic [1:0]       r_sel;
    logic [CNT_W-1:0] r_cnt;

    logic             w_load;
    logic             w_any;
    logic [1:0]       w_gnt;
    logic [1:0]       w_idx;
    logic             w_take;
    logic [WIDTH-1:0] w_dat;

    // Slot can take a word when it is empty or is being drained this cycle.
    assign w_load = !r_vy | ry;
    assign w_take = w_load & w_any & rst_n;

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        w_any = 1'b0;
        w_gnt = r_lp;
        w_idx = r_lp;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_lp + 2'(k);
            if (!w_any && v[w_idx]) begin
                w_any = 1'b1;
                w_gnt = w_idx;
            end
        end
    end

    // Ready goes only to the granted channel, and only when the slot is free.
    always_comb begin
        rdy_311 = 4'b0000;
        if (w_take) begin
            rdy_311 = 4'b0001 << w_gnt;
        end
    end

    // Select the granted channel's data.
    always_comb begin
        w_dat = i0;
        case (w_gnt)
            2'd0: w_dat = i0;
            2'd1: w_dat = i1;
            2'd2: w_dat = i2;
            2'd3: w_dat = i3;
            default: w_dat = i0;
        endcase
    end

    // Output slot, source tag, pointer and counter; pointer moves only on acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lp  <= 2'd3;
            r_y   <= '0;
            r_vy  <= 1'b0;
            r_sel <= 2'd0;
            r_cnt <= '0;
        end else if (w_take) begin
            r_y   <= w_dat;
            r_sel <= w_gnt;
            r_vy  <= 1'b1;
            r_lp  <= w_gnt;
            r_cnt <= r_cnt + 1'b1;
        end else if (r_vy && ry) begin
            r_vy <= 1'b0;
        end
    end

    assign y_311   = r_y;
    assign vy_311  = r_vy;
    assign s1_311  = r_sel[1];
    assign s0_311  = r_sel[0];
    assign cnt_311 = r_cnt;

endmodule
